// File: rtl/bpf_loader_pkg.sv
// Shared types and constants for the BPF instruction loader.
//
// Contents:
//   loader_state_t  - loader FSM states (IDLE, LOW_PENDING, RUN)
//   INST_WIDTH      - assembled instruction width (64)
//   HALF_WIDTH      - width of each register half (32)
package bpf_loader_pkg;

    localparam int INST_WIDTH = 64;
    localparam int HALF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LOW_PENDING = 2'd1,
        RUN         = 2'd2
    } loader_state_t;

endpackage

// File: rtl/bpf_inst_loader.sv
// bpf_inst_loader
//
// Assembles inst_low/inst_high register writes into 64-bit BPF instructions
// and streams them into the BPF core's instruction memory at an
// auto-incrementing address. The Control.start level gates the core: the
// program can be loaded only while start=0 and the core runs only while
// start=1. Leaving RUN rewinds the write pointer so the next load starts at 0.
//
// Ports:
//   clk, rst          - single clock, synchronous active-high reset
//   inst_low_value    - inst_low register value
//   inst_low_strobe   - one-cycle pulse, inst_low written
//   inst_high_value   - inst_high register value
//   inst_high_strobe  - one-cycle pulse, inst_high written (completes a pair)
//   control_start     - Control.start level
//   inst_wr_en        - instruction memory write enable (one cycle per pair)
//   inst_wr_addr      - instruction memory write address
//   inst_wr_data      - {high, low} instruction word
//   cpu_en            - BPF core run enable
//   inst_count        - instructions loaded since the last clear
//   seq_err           - sticky: orphan high strobe, or any strobe while running
//   overflow          - sticky: a pair was offered with the memory full
//   checksum          - (BPF_INST_LOADER_CHECKSUM_EN only) XOR of low^high over
//                       every written instruction
//
// Optional feature macro: BPF_INST_LOADER_CHECKSUM_EN
//
// Handshake: the strobes are fire-and-forget pulses with no back-pressure;
// a pair is complete on the cycle a high strobe arrives with a low already
// latched or arriving in the same cycle, and the memory write appears on the
// following cycle as a single-cycle inst_wr_en.
module bpf_inst_loader
    import bpf_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HALF_WIDTH-1:0] inst_low_value,
    input  logic                  inst_low_strobe,
    input  logic [HALF_WIDTH-1:0] inst_high_value,
    input  logic                  inst_high_strobe,
    input  logic                  control_start,
    output logic                  inst_wr_en,
    output logic [ADDR_WIDTH-1:0] inst_wr_addr,
    output logic [INST_WIDTH-1:0] inst_wr_data,
    output logic                  cpu_en,
    output logic [ADDR_WIDTH:0]   inst_count,
    output logic                  seq_err,
    output logic                  overflow
`ifdef BPF_INST_LOADER_CHECKSUM_EN
    ,
    output logic [HALF_WIDTH-1:0] checksum
`endif
);

    // wr_ptr is one bit wider than the address so that "memory full"
    // (wr_ptr == DEPTH) is representable without wrapping.
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    loader_state_t         state;
    logic                  start_q;
    logic [HALF_WIDTH-1:0] low_latch;
    logic [ADDR_WIDTH:0]   wr_ptr;

    logic                  start_rise;
    logic                  loading;
    logic                  mem_full;
    logic                  pair_done;
    logic                  orphan_high;
    logic [HALF_WIDTH-1:0] low_now;

    assign start_rise  = control_start & ~start_q;
    assign loading     = (state != RUN);
    assign mem_full    = (wr_ptr == FULL_COUNT);

    // A low strobe in the same cycle as the high strobe is taken as
    // "low first", so its value wins over anything already latched.
    assign low_now     = inst_low_strobe ? inst_low_value : low_latch;

    assign pair_done   = loading & inst_high_strobe &
                         (inst_low_strobe | (state == LOW_PENDING));
    assign orphan_high = loading & inst_high_strobe & ~inst_low_strobe &
                         (state == IDLE);

    assign inst_count  = wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            start_q      <= 1'b0;
            low_latch    <= '0;
            wr_ptr       <= '0;
            inst_wr_en   <= 1'b0;
            inst_wr_addr <= '0;
            inst_wr_data <= '0;
            cpu_en       <= 1'b0;
            seq_err      <= 1'b0;
            overflow     <= 1'b0;
`ifdef BPF_INST_LOADER_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            start_q    <= control_start;
            inst_wr_en <= 1'b0;

            if (state == RUN) begin
                if (!control_start) begin
                    // Leaving RUN clears the load bookkeeping; memory
                    // contents stay and are overwritten by the next load.
                    state    <= IDLE;
                    cpu_en   <= 1'b0;
                    wr_ptr   <= '0;
                    seq_err  <= 1'b0;
                    overflow <= 1'b0;
`ifdef BPF_INST_LOADER_CHECKSUM_EN
                    checksum <= '0;
`endif
                end else if (inst_low_strobe || inst_high_strobe) begin
                    seq_err <= 1'b1;
                end
            end else begin
                if (inst_low_strobe) begin
                    low_latch <= inst_low_value;
                end

                // A pair completing on the start-rise cycle is still
                // written; its write lands in the first RUN cycle.
                if (pair_done) begin
                    if (mem_full) begin
                        overflow <= 1'b1;
                    end else begin
                        inst_wr_en   <= 1'b1;
                        inst_wr_addr <= wr_ptr[ADDR_WIDTH-1:0];
                        inst_wr_data <= {inst_high_value, low_now};
                        wr_ptr       <= wr_ptr + 1'b1;
`ifdef BPF_INST_LOADER_CHECKSUM_EN
                        checksum     <= checksum ^ inst_high_value ^ low_now;
`endif
                    end
                end

                if (orphan_high) begin
                    seq_err <= 1'b1;
                end

                if (start_rise) begin
                    // Any half-loaded pair is abandoned on entry to RUN.
                    state  <= RUN;
                    cpu_en <= 1'b1;
                end else if (pair_done) begin
                    state <= IDLE;
                end else if (inst_low_strobe) begin
                    state <= LOW_PENDING;
                end
            end
        end
    end

endmodule

// File: tb/tb_bpf_inst_loader.sv
// Self-checking bench for bpf_inst_loader (ADDR_WIDTH=2, four-entry memory).
// A table of per-cycle vectors covers loading, orphan/same-cycle strobes,
// overflow and the RUN gating; hand-written sequences cover reset mid-pair,
// start held high across reset, and the optional checksum.
module tb_bpf_inst_loader;

    localparam int AW = 2;

    logic          clk;
    logic          rst;
    logic [31:0]   inst_low_value;
    logic          inst_low_strobe;
    logic [31:0]   inst_high_value;
    logic          inst_high_strobe;
    logic          control_start;
    logic          inst_wr_en;
    logic [AW-1:0] inst_wr_addr;
    logic [63:0]   inst_wr_data;
    logic          cpu_en;
    logic [AW:0]   inst_count;
    logic          seq_err;
    logic          overflow;
`ifdef BPF_INST_LOADER_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bpf_inst_loader #(.ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .inst_low_value   (inst_low_value),
        .inst_low_strobe  (inst_low_strobe),
        .inst_high_value  (inst_high_value),
        .inst_high_strobe (inst_high_strobe),
        .control_start    (control_start),
        .inst_wr_en       (inst_wr_en),
        .inst_wr_addr     (inst_wr_addr),
        .inst_wr_data     (inst_wr_data),
        .cpu_en           (cpu_en),
        .inst_count       (inst_count),
        .seq_err          (seq_err),
        .overflow         (overflow)
`ifdef BPF_INST_LOADER_CHECKSUM_EN
        ,
        .checksum         (checksum)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vectors ----------------
    typedef struct {
        logic        ls;
        logic [31:0] lv;
        logic        hs;
        logic [31:0] hv;
        logic        st;
        logic        we;
        logic [1:0]  addr;
        logic [63:0] data;
        logic        cpu;
        logic [2:0]  cnt;
        logic        se;
        logic        ov;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    function automatic vec_t mk(logic ls, logic [31:0] lv, logic hs, logic [31:0] hv,
                                logic st, logic we, logic [1:0] addr, logic [63:0] data,
                                logic cpu, logic [2:0] cnt, logic se, logic ov);
        vec_t v;
        v.ls = ls; v.lv = lv; v.hs = hs; v.hv = hv; v.st = st;
        v.we = we; v.addr = addr; v.data = data; v.cpu = cpu;
        v.cnt = cnt; v.se = se; v.ov = ov;
        return v;
    endfunction

    // ---------------- driver / checker ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic ls, input logic [31:0] lv,
                        input logic hs, input logic [31:0] hv, input logic st);
        inst_low_strobe  = ls;
        inst_low_value   = lv;
        inst_high_strobe = hs;
        inst_high_value  = hv;
        control_start    = st;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic we, input logic [1:0] addr,
                             input logic [63:0] data, input logic cpu, input logic [2:0] cnt,
                             input logic se, input logic ov);
        check({tag, ".inst_wr_en"},   64'(inst_wr_en),   64'(we));
        check({tag, ".inst_wr_addr"}, 64'(inst_wr_addr), 64'(addr));
        check({tag, ".inst_wr_data"}, inst_wr_data,      data);
        check({tag, ".cpu_en"},       64'(cpu_en),       64'(cpu));
        check({tag, ".inst_count"},   64'(inst_count),   64'(cnt));
        check({tag, ".seq_err"},      64'(seq_err),      64'(se));
        check({tag, ".overflow"},     64'(overflow),     64'(ov));
    endtask

    localparam logic [63:0] D_C28 = 64'h0000000C_00000028;
    localparam logic [63:0] D_06  = 64'h00000000_00000006;
    localparam logic [63:0] D_21  = 64'h22222222_11111111;
    localparam logic [63:0] D_BA  = 64'h0000000B_0000000A;
    localparam logic [63:0] D_12  = 64'h00000002_00000001;

    initial begin
        // ls lv hs hv st | we addr data cpu cnt se ov
        vecs[0]  = mk(1, 32'h28, 0, 0, 0,             0, 0, 0,     0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 1, 32'h0C, 0,             1, 0, D_C28, 0, 1, 0, 0);
        vecs[2]  = mk(1, 32'h06, 0, 0, 0,             0, 0, D_C28, 0, 1, 0, 0);
        vecs[3]  = mk(0, 0, 1, 32'h00, 0,             1, 1, D_06,  0, 2, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0,                  0, 1, D_06,  0, 2, 0, 0);
        vecs[5]  = mk(0, 0, 1, 32'hDEADBEEF, 0,       0, 1, D_06,  0, 2, 1, 0);
        vecs[6]  = mk(1, 32'h11111111, 1, 32'h22222222, 0, 1, 2, D_21, 0, 3, 1, 0);
        vecs[7]  = mk(0, 0, 1, 32'h33, 0,             0, 2, D_21,  0, 3, 1, 0);
        vecs[8]  = mk(1, 32'h0A, 0, 0, 0,             0, 2, D_21,  0, 3, 1, 0);
        vecs[9]  = mk(0, 0, 1, 32'h0B, 0,             1, 3, D_BA,  0, 4, 1, 0);
        vecs[10] = mk(1, 32'h0C, 0, 0, 0,             0, 3, D_BA,  0, 4, 1, 0);
        vecs[11] = mk(0, 0, 1, 32'h0D, 0,             0, 3, D_BA,  0, 4, 1, 1);
        vecs[12] = mk(0, 0, 0, 0, 1,                  0, 3, D_BA,  1, 4, 1, 1);
        vecs[13] = mk(0, 0, 0, 0, 0,                  0, 3, D_BA,  0, 0, 0, 0);
        vecs[14] = mk(1, 32'h05, 0, 0, 0,             0, 3, D_BA,  0, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 0, 1,                  0, 3, D_BA,  1, 0, 0, 0);
        vecs[16] = mk(0, 0, 1, 32'h07, 1,             0, 3, D_BA,  1, 0, 1, 0);
        vecs[17] = mk(1, 32'h08, 0, 0, 1,             0, 3, D_BA,  1, 0, 1, 0);
        vecs[18] = mk(0, 0, 0, 0, 0,                  0, 3, D_BA,  0, 0, 0, 0);
        vecs[19] = mk(0, 0, 1, 32'h09, 0,             0, 3, D_BA,  0, 0, 1, 0);
        vecs[20] = mk(1, 32'h01, 0, 0, 0,             0, 3, D_BA,  0, 0, 1, 0);
        vecs[21] = mk(0, 0, 1, 32'h02, 0,             1, 0, D_12,  0, 1, 1, 0);
        vecs[22] = mk(0, 0, 0, 0, 0,                  0, 0, D_12,  0, 1, 1, 0);

        // ---------------- reset ----------------
        rst = 1'b1;
        inst_low_strobe = 0; inst_low_value = 0;
        inst_high_strobe = 0; inst_high_value = 0;
        control_start = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].ls, vecs[i].lv, vecs[i].hs, vecs[i].hv, vecs[i].st);
            check_all($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data,
                      vecs[i].cpu, vecs[i].cnt, vecs[i].se, vecs[i].ov);
        end

        // ---------------- reset mid-pair ----------------
        step(1, 32'h44, 0, 0, 0);
        rst = 1'b1;
        step(0, 0, 1, 32'h55, 0);
        check_all("rst_mid_pair", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h66, 0);
        check_all("after_rst_orphan", 0, 0, 0, 0, 0, 1, 0);

        // ---------------- start held across reset ----------------
        rst = 1'b1;
        step(0, 0, 0, 0, 1);
        check("start_in_rst.cpu_en", 64'(cpu_en), 64'd0);
        rst = 1'b0;
        step(0, 0, 0, 0, 1);
        check("start_at_release.cpu_en", 64'(cpu_en), 64'd1);
        check("start_at_release.inst_count", 64'(inst_count), 64'd0);
        step(0, 0, 0, 0, 0);
        check("start_drop.cpu_en", 64'(cpu_en), 64'd0);

`ifdef BPF_INST_LOADER_CHECKSUM_EN
        // ---------------- checksum ----------------
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        check("cks_reset", 64'(checksum), 64'd0);
        rst = 1'b0;
        step(1, 32'h0000000F, 0, 0, 0);
        step(0, 0, 1, 32'h000000F0, 0);
        check("cks_first.wr_en", 64'(inst_wr_en), 64'd1);
        check("cks_first", 64'(checksum), 64'h000000FF);
        step(1, 32'h00000100, 0, 0, 0);
        step(0, 0, 1, 32'h00000000, 0);
        check("cks_second", 64'(checksum), 64'h000001FF);
        step(0, 0, 0, 0, 1);
        check("cks_in_run", 64'(checksum), 64'h000001FF);
        step(0, 0, 0, 0, 0);
        check("cks_cleared", 64'(checksum), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
